// File: rtl/seg_pkg.sv
// Shared codes, segment patterns and scan states for the 7-segment display path.
package seg_pkg;

  localparam logic [10:0] CODE_DASH  = 11'd11;
  localparam logic [10:0] CODE_BLANK = 11'd12;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    S_BLANK,
    S_SAMPLE,
    S_SHOW
  } state_e;

endpackage

// File: rtl/seg_scan_driver_if.sv
// Digit-content selector link: the scanner presents light and the selector
// answers combinationally with num/dot for that digit.
interface seg_scan_driver_if;
  logic [2:0]  light;
  logic [10:0] num;
  logic        dot;

  modport master (output light, input num, input dot);
  modport slave  (input light, output num, output dot);
endinterface

// File: rtl/seg7_decode.sv
// Combinational digit-code to active-low segment decoder (bit0=a .. bit6=g).
module seg7_decode
  import seg_pkg::*;
(
  input  logic [10:0] i_num,
  output logic [6:0]  o_seg_n
);

  // Full 11-bit compare so high-bit garbage never aliases onto a digit.
  always_comb begin
    o_seg_n = SEG_BLANK;
    case (i_num)
      11'd0:      o_seg_n = 7'h40;
      11'd1:      o_seg_n = 7'h79;
      11'd2:      o_seg_n = 7'h24;
      11'd3:      o_seg_n = 7'h30;
      11'd4:      o_seg_n = 7'h19;
      11'd5:      o_seg_n = 7'h12;
      11'd6:      o_seg_n = 7'h02;
      11'd7:      o_seg_n = 7'h78;
      11'd8:      o_seg_n = 7'h00;
      11'd9:      o_seg_n = 7'h10;
      CODE_DASH:  o_seg_n = SEG_DASH;
      CODE_BLANK: o_seg_n = SEG_BLANK;
      default:    o_seg_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit 7-segment scanner with per-slot blanking.
// Optional SEG_BLINK_EN adds blink_mask/BLINK_DIV for a blinking edit cursor.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIV_CNT      = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int NUM_DIGITS   = 8
`ifdef SEG_BLINK_EN
  ,
  parameter int BLINK_DIV    = 25000000
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  seg_scan_driver_if.master        sel,
`ifdef SEG_BLINK_EN
  input  logic [7:0]               blink_mask,
`endif
  output logic [6:0]               seg_n,
  output logic                     dp_n,
  output logic [7:0]               an_n,
  output logic                     frame_done
);

  localparam int CNT_W = $clog2(DIV_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV_CNT - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [2:0]       LIGHT_LAST = 3'(NUM_DIGITS - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       r_light;
  logic [2:0]       w_light_nxt;
  logic [7:0]       r_an_n;
  logic [7:0]       w_an_nxt;
  logic             r_frame_done;
  logic             w_frame_nxt;
  logic [6:0]       r_seg_n;
  logic             r_dp_n;
  logic             w_load;
  logic [6:0]       w_dec_seg_n;
  logic             w_blink_hide;

  seg7_decode u_decode (
    .i_num   (sel.num),
    .o_seg_n (w_dec_seg_n)
  );

`ifdef SEG_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_on;

  // Free-running so the cursor rhythm is independent of scan enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt <= '0;
      r_blink_on  <= ~r_blink_on;
    end else begin
      r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
    end
  end

  assign w_blink_hide = ~r_blink_on & blink_mask[r_light];
`else
  assign w_blink_hide = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_BLANK;
    else        r_state <= w_state_nxt;
  end

  // Enable dominates slot end, which dominates the per-state progression.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_light_nxt = r_light;
    w_frame_nxt = 1'b0;
    w_load      = 1'b0;
    if (!en) begin
      w_state_nxt = S_BLANK;
      w_cnt_nxt   = '0;
    end else if (r_cnt == CNT_LAST) begin
      w_state_nxt = S_BLANK;
      w_cnt_nxt   = '0;
      w_light_nxt = (r_light == LIGHT_LAST) ? 3'd0 : r_light + 3'd1;
      w_frame_nxt = (r_light == LIGHT_LAST);
    end else begin
      case (r_state)
        S_BLANK:  if (r_cnt == BLANK_LAST) w_state_nxt = S_SAMPLE;
        S_SAMPLE: begin
          w_load      = 1'b1;
          w_state_nxt = S_SHOW;
        end
        S_SHOW:   w_state_nxt = S_SHOW;
        default:  w_state_nxt = S_BLANK;
      endcase
    end
    // Anodes are registered from the next state so they line up with it.
    w_an_nxt = (w_state_nxt == S_SHOW && !w_blink_hide) ? ~(8'd1 << r_light) : 8'hFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_light      <= 3'd0;
      r_an_n       <= 8'hFF;
      r_frame_done <= 1'b0;
      r_seg_n      <= SEG_BLANK;
      r_dp_n       <= 1'b1;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_light      <= w_light_nxt;
      r_an_n       <= w_an_nxt;
      r_frame_done <= w_frame_nxt;
      if (w_load) begin
        r_seg_n <= w_dec_seg_n;
        r_dp_n  <= sel.dot;
      end
    end
  end

  assign sel.light  = r_light;
  assign seg_n      = r_seg_n;
  assign dp_n       = r_dp_n;
  assign an_n       = r_an_n;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: slot-position model compared every cycle plus pinned literals.
module tb_seg_scan_driver;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int NUM   = 8;

  localparam logic [6:0] DIGIT_PAT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [7:0] an_n;
  logic       frame_done;

  logic [10:0] num_tab [NUM];
  logic        dot_tab [NUM];

  int n_checks;
  int n_pass;
  int n_fail;

  seg_scan_driver_if ifc ();

  seg_scan_driver #(
    .DIV_CNT      (DIV),
    .BLANK_CYCLES (BLANK),
    .NUM_DIGITS   (NUM)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .sel        (ifc.master),
`ifdef SEG_BLINK_EN
    .blink_mask (8'h00),
`endif
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Selector: combinational lookup of the digit content for the presented light.
  always_comb begin
    ifc.num = num_tab[ifc.light];
    ifc.dot = dot_tab[ifc.light];
  end

  function automatic logic [6:0] ref_seg(input logic [10:0] code);
    if (code < 11'd10) return DIGIT_PAT[code[3:0]];
    if (code == 11'd11) return 7'h3F;
    return 7'h7F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position p within the slot, current digit, and the last sampled pattern.
  int         p;
  logic [2:0] light_m;
  logic [6:0] seg_m;
  logic       dp_m;
  logic       fd_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p       <= 0;
      light_m <= 3'd0;
      seg_m   <= 7'h7F;
      dp_m    <= 1'b1;
      fd_m    <= 1'b0;
    end else if (!en) begin
      p    <= 0;
      fd_m <= 1'b0;
    end else if (p == DIV - 1) begin
      p       <= 0;
      fd_m    <= (light_m == 3'(NUM - 1));
      light_m <= 3'((int'(light_m) + 1) % NUM);
    end else begin
      fd_m <= 1'b0;
      if (p == BLANK) begin
        seg_m <= ref_seg(num_tab[light_m]);
        dp_m  <= dot_tab[light_m];
      end
      p <= p + 1;
    end
  end

  always @(negedge clk) begin
    logic [7:0] an_exp;
    an_exp = (p >= BLANK + 1) ? ~(8'd1 << light_m) : 8'hFF;
    check("model_light", 32'(ifc.light), 32'(light_m));
    check("model_an_n", 32'(an_n), 32'(an_exp));
    check("model_seg_n", 32'(seg_n), 32'(seg_m));
    check("model_dp_n", 32'(dp_n), 32'(dp_m));
    check("model_frame_done", 32'(frame_done), 32'(fd_m));
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_light"}, 32'(ifc.light), 32'd0);
    check({tag, "_seg_n"}, 32'(seg_n), 32'h7F);
    check({tag, "_dp_n"}, 32'(dp_n), 32'd1);
    check({tag, "_an_n"}, 32'(an_n), 32'hFF);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_fail   = 0;
    en       = 1'b1;
    rst_n    = 1'b1;
    for (int i = 0; i < NUM; i++) begin
      num_tab[i] = 11'd5;
      dot_tab[i] = 1'b1;
    end
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;                          // cycle 0 of the first slot

    repeat (2) @(negedge clk);             // cycle 2: sampling, still dark
    check("c2_an_n", 32'(an_n), 32'hFF);
    @(negedge clk);                        // cycle 3: first lit cycle
    check("c3_an_n", 32'(an_n), 32'hFE);
    check("c3_seg_n", 32'(seg_n), 32'h12);
    check("c3_dp_n", 32'(dp_n), 32'd1);
    repeat (4) @(negedge clk);             // cycle 7: last lit cycle
    check("c7_an_n", 32'(an_n), 32'hFE);
    @(negedge clk);                        // cycle 8: next digit, blanked
    check("c8_light", 32'(ifc.light), 32'd1);
    check("c8_an_n", 32'(an_n), 32'hFF);

    num_tab[0] = 11'd1; num_tab[1] = 11'd2; num_tab[2] = 11'd11; num_tab[3] = 11'd3;
    num_tab[4] = 11'd4; num_tab[5] = 11'd11; num_tab[6] = 11'd5; num_tab[7] = 11'd6;
    dot_tab[3] = 1'b0;

    repeat (11) @(negedge clk);            // cycle 19: digit 2 lit
    check("dash_an_n", 32'(an_n), 32'hFB);
    check("dash_seg_n", 32'(seg_n), 32'h3F);
    repeat (8) @(negedge clk);             // cycle 27: digit 3 lit with dot
    check("dot_an_n", 32'(an_n), 32'hF7);
    check("dot_seg_n", 32'(seg_n), 32'h30);
    check("dot_dp_n", 32'(dp_n), 32'd0);
    repeat (37) @(negedge clk);            // cycle 64: wrap to digit 0
    check("wrap_light", 32'(ifc.light), 32'd0);
    check("wrap_frame_done", 32'(frame_done), 32'd1);
    @(negedge clk);                        // cycle 65
    check("wrap_frame_done_low", 32'(frame_done), 32'd0);
    num_tab[0] = 11'd13; num_tab[1] = 11'd12; num_tab[2] = 11'd10; num_tab[3] = 11'h405;

    repeat (2) @(negedge clk);             // cycle 67: code 13 decodes blank
    check("code13_an_n", 32'(an_n), 32'hFE);
    check("code13_seg_n", 32'(seg_n), 32'h7F);

    repeat (29) @(negedge clk);            // cycle 96: digit 4 slot start
    check("en_slot_light", 32'(ifc.light), 32'd4);
    repeat (5) @(negedge clk);             // cycle 101: slot cycle 5
    en = 1'b0;
    @(negedge clk);
    check("en_low_an_n", 32'(an_n), 32'hFF);
    check("en_low_light", 32'(ifc.light), 32'd4);
    repeat (3) @(negedge clk);
    check("en_low_hold_light", 32'(ifc.light), 32'd4);
    check("en_low_hold_an_n", 32'(an_n), 32'hFF);
    en = 1'b1;
    repeat (2) @(negedge clk);
    check("en_resume_blank", 32'(an_n), 32'hFF);
    @(negedge clk);
    check("en_resume_an_n", 32'(an_n), 32'hEF);
    check("en_resume_light", 32'(ifc.light), 32'd4);

    repeat (16) @(negedge clk);            // digit 6 lit
    check("pre_rst_light", 32'(ifc.light), 32'd6);
    check("pre_rst_an_n", 32'(an_n), 32'hBF);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("restart_light", 32'(ifc.light), 32'd0);
    check("restart_an_n", 32'(an_n), 32'hFE);
    check("restart_seg_n", 32'(seg_n), 32'h7F);

    repeat (70) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
